// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipeline results have absolute priority, long-latency (lsu) results queue in a small FIFO.
// Latency: pipeline 0 cycles (combinational); lsu >= 1 cycle through the FIFO (0 cycles on the bypass path).
// Backpressure: lsu_ready drops when the FIFO is full; the pipeline port is never stalled.
//
// Optional feature macro: WB_ARBITER_BYPASS_EN
//   When defined, an lsu result arriving with the FIFO empty and the pipeline idle
//   is written in the same cycle instead of being queued.
//
// Ports:
//   clk, reset                    rising-edge clock, asynchronous active-high reset
//   pipe_valid/pipe_rd/pipe_data  main-pipeline writeback request (never stalled)
//   lsu_valid/lsu_ready           long-latency result handshake
//   lsu_rd/lsu_data               long-latency result
//   issue_valid/issue_rd          long-latency issue; marks issue_rd pending
//   reg_write/waddr/wdata         register-file write port
//   busy                          per-register pending bitmap (bit 0 always 0)
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        reg_write,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic [31:0] busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] dat;
  } wb_entry_t;

  wb_entry_t     mem [DEPTH];
  wb_entry_t     head;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] count;
  logic [31:0]   busy_q;
  logic [31:0]   busy_d;

  logic          pipe_wr;
  logic          fifo_empty;
  logic          pop;
  logic          bypass;
  logic          push;
  logic          clr_vld;
  logic [4:0]    clr_rd;

  assign head       = mem[rptr];
  assign fifo_empty = (count == '0);

  // Occupancy-only, so the handshake never depends on this cycle's inputs.
  assign lsu_ready  = (count < FULL);
  assign busy       = busy_q;

  // Everything that can produce a write is masked while reset is held, so the
  // register file sees no writes until reset is released.
  assign pipe_wr = !reset && pipe_valid && (pipe_rd != 5'd0);
  assign pop     = !reset && !pipe_wr && !fifo_empty;

`ifdef WB_ARBITER_BYPASS_EN
  assign bypass = !reset && !pipe_wr && fifo_empty && lsu_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push = !reset && lsu_valid && lsu_ready && !bypass;

  always_comb begin
    reg_write = 1'b0;
    waddr     = 5'd0;
    wdata     = 32'd0;
    clr_vld   = 1'b0;
    clr_rd    = 5'd0;
    if (pipe_wr) begin
      reg_write = 1'b1;
      waddr     = pipe_rd;
      wdata     = pipe_data;
    end else if (pop) begin
      // rd=0 entries are still consumed, just never written.
      reg_write = (head.rd != 5'd0);
      waddr     = head.rd;
      wdata     = head.dat;
      clr_vld   = 1'b1;
      clr_rd    = head.rd;
    end else if (bypass) begin
      reg_write = (lsu_rd != 5'd0);
      waddr     = lsu_rd;
      wdata     = lsu_data;
      clr_vld   = 1'b1;
      clr_rd    = lsu_rd;
    end
  end

  // Set is applied after clear so a same-cycle re-issue keeps the bit pending.
  always_comb begin
    busy_d = busy_q;
    if (clr_vld) begin
      busy_d[clr_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= '{rd: lsu_rd, dat: lsu_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr   <= '0;
      wptr   <= '0;
      count  <= '0;
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed stimulus, expected register-file writes are
// queued as stimulus is issued and a negedge monitor compares every reg_write.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        reg_write;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] busy;

  int compared = 0;
  int mismatched = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  wb_arbiter #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .reg_write  (reg_write),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every register-file write must match the queue head.
  always @(negedge clk) begin
    if (!reset && reg_write) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got rd=%0d data=%h expected no write at %0t",
                 waddr, wdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_write", {27'd0, waddr, wdata}, {27'd0, mon_e});
      end
    end
  end

  initial begin
    reset = 1'b1;
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h1234_5678;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;

    // Reset state; a pipeline request under reset must not write.
    #12;
    chk("rst_write_masked", {63'd0, reg_write}, 64'd0);
    pipe_valid = 1'b0;
    #1;
    chk("rst_lsu_ready", {63'd0, lsu_ready}, 64'd1);
    chk("rst_reg_write", {63'd0, reg_write}, 64'd0);
    chk("rst_waddr", {59'd0, waddr}, 64'd0);
    chk("rst_wdata", {32'd0, wdata}, 64'd0);
    chk("rst_busy", {32'd0, busy}, 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // Pipeline write is combinational, same cycle.
    exp_q.push_back({5'd5, 32'hAAAA_BBBB});
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hAAAA_BBBB;
    #1;
    chk("pipe_same_cycle", {63'd0, reg_write}, 64'd1);
    tick();
    pipe_valid = 1'b0;

    // Pending bit held until the lsu result is written.
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    chk("busy7_set", {63'd0, busy[7]}, 64'd1);
    exp_q.push_back({5'd7, 32'hCCCC_DDDD});
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hCCCC_DDDD;
    #1;
    chk("lsu_ready_empty", {63'd0, lsu_ready}, 64'd1);
    tick();
    lsu_valid = 1'b0;
`ifndef WB_ARBITER_BYPASS_EN
    chk("busy7_until_write", {63'd0, busy[7]}, 64'd1);
    tick();
`endif
    chk("busy7_cleared", {63'd0, busy[7]}, 64'd0);

    // rd=0 entry: consumed silently (monitor flags any write).
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF_FFFF;
    tick();
    lsu_valid = 1'b0;
    #1;
    chk("rd0_no_write", {63'd0, reg_write}, 64'd0);
    tick();
    tick();

    // Pipeline busy 6 cycles while lsu fills the FIFO; a full FIFO must refuse
    // further offers (rd=31 would show up as an unexpected write).
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({5'(i + 1), 32'h1000_0000 + 32'(i)});
      pipe_valid = 1'b1; pipe_rd = 5'(i + 1); pipe_data = 32'h1000_0000 + 32'(i);
      lsu_valid = 1'b1;
      if (i < 4) begin
        lsu_rd = 5'(10 + i); lsu_data = 32'h2000_0000 + 32'(i);
        chk("lsu_ready_fill", {63'd0, lsu_ready}, 64'd1);
      end else begin
        lsu_rd = 5'd31; lsu_data = 32'hDEAD_BEEF;
        chk("lsu_ready_full", {63'd0, lsu_ready}, 64'd0);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({5'(10 + i), 32'h2000_0000 + 32'(i)});
    end
    pipe_valid = 1'b0; lsu_valid = 1'b0;
    tick();
    chk("lsu_ready_after_pop", {63'd0, lsu_ready}, 64'd1);
    repeat (4) tick();

    // Three queued entries with pending bits 4..6, then reset discards them.
    for (int j = 0; j < 3; j++) begin
      exp_q.push_back({5'd2, 32'h3000_0000 + 32'(j)});
      pipe_valid = 1'b1; pipe_rd = 5'd2; pipe_data = 32'h3000_0000 + 32'(j);
      issue_valid = 1'b1; issue_rd = 5'(4 + j);
      lsu_valid = 1'b1; lsu_rd = 5'(4 + j); lsu_data = 32'h4000_0000 + 32'(j);
      tick();
    end
    issue_valid = 1'b0; lsu_valid = 1'b0;
    chk("busy_pre_reset", {32'd0, busy}, 64'h0000_0070);
    pipe_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_lsu_ready", {63'd0, lsu_ready}, 64'd1);
    chk("mid_rst_reg_write", {63'd0, reg_write}, 64'd0);
    chk("mid_rst_waddr", {59'd0, waddr}, 64'd0);
    chk("mid_rst_wdata", {32'd0, wdata}, 64'd0);
    chk("mid_rst_busy", {32'd0, busy}, 64'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("release_no_write", {63'd0, reg_write}, 64'd0);
    repeat (4) tick();

    // Same-cycle issue and head write on rd=9: set wins.
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    exp_q.push_back({5'd9, 32'h9999_0000});
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9999_0000;
`ifdef WB_ARBITER_BYPASS_EN
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0; lsu_valid = 1'b0;
`else
    tick();
    lsu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
`endif
    chk("busy9_set_wins", {63'd0, busy[9]}, 64'd1);
    tick();
    chk("busy9_held", {63'd0, busy[9]}, 64'd1);

    repeat (3) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the late-result FIFO entry count (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pipe_valid  input  1  main-pipeline writeback request this cycle (never stalled).
REQ-005 SHALL have port pipe_rd  input  5  main-pipeline destination register.
REQ-006 SHALL have port pipe_data  input  32  main-pipeline result.
REQ-007 SHALL have port lsu_valid  input  1  long-latency unit result offered.
REQ-008 SHALL have port lsu_ready  output  1  arbiter accepts lsu result this cycle.
REQ-009 SHALL have port lsu_rd  input  5  long-latency destination register.
REQ-010 SHALL have port lsu_data  input  32  long-latency result.
REQ-011 SHALL have port issue_valid  input  1  long-latency op issued; mark issue_rd pending.
REQ-012 SHALL have port issue_rd  input  5  destination of issued long-latency op.
REQ-013 SHALL have port reg_write  output  1  register-file write enable.
REQ-014 SHALL have port waddr  output  5  register-file write address.
REQ-015 SHALL have port wdata  output  32  register-file write data.
REQ-016 SHALL have port busy  output  32  per-register pending bitmap; bit 0 always 0.

Function
REQ-017 SHALL accept an lsu result on a cycle with lsu_valid=1 and lsu_ready=1, pushing {lsu_rd, lsu_data} into the FIFO.
REQ-018 SHALL drive lsu_ready = (FIFO occupancy < DEPTH), from registered state only.
REQ-019 SHALL give the pipeline port absolute priority: pipe_valid=1 with pipe_rd!=0 -> reg_write=1, waddr=pipe_rd, wdata=pipe_data, same cycle, combinational.
REQ-020 SHALL pop the FIFO head on any cycle the pipeline port is not writing (pipe_valid=0 or pipe_rd=0) and FIFO is non-empty; head drives waddr/wdata.
REQ-021 SHALL suppress reg_write for any selected entry whose rd=0, while still popping it.
REQ-022 SHALL drive reg_write=0, waddr=0, wdata=0 when nothing is selected.
REQ-023 SHALL support push and pop in the same cycle; occupancy is then unchanged.
REQ-024 SHALL wrap read/write pointers modulo DEPTH, with occupancy counter width clog2(DEPTH)+1.
REQ-025 SHALL set busy[issue_rd] on issue_valid=1 with issue_rd!=0.
REQ-026 SHALL clear busy[r] on a cycle the FIFO head with rd=r is written.
REQ-027 SHALL let set win over clear when both target the same bit in one cycle.
REQ-028 SHALL never change busy on pipeline-port writes.

Reset
REQ-029 SHALL, while reset=1, asynchronously clear FIFO pointers, occupancy and busy; outputs read lsu_ready=1, reg_write=0, waddr=0, wdata=0, busy=0.
REQ-030 SHALL discard all FIFO contents on reset asserted mid-operation; no write issues in the reset-release cycle unless pipe_valid=1.

Configuration
REQ-031 SHALL honour macro WB_ARBITER_BYPASS_EN.
REQ-032 With WB_ARBITER_BYPASS_EN defined: FIFO empty, pipeline port not writing, lsu_valid=1 -> lsu result written same cycle, not pushed; busy bit cleared that cycle.
REQ-033 Without WB_ARBITER_BYPASS_EN: every lsu result passes through the FIFO; minimum accept-to-write latency is one cycle.

Verification
REQ-034 Reset then pipe_valid=1, pipe_rd=5, pipe_data=32'hAAAA_BBBB -> same cycle reg_write=1, waddr=5, wdata=32'hAAAA_BBBB.
REQ-035 issue_rd=7, then lsu push rd=7 data=32'hCCCC_DDDD with pipe idle -> busy[7]=1 until the write cycle; written one cycle later (same cycle with bypass), then busy[7]=0.
REQ-036 pipe_valid=1 for 6 cycles while lsu pushes 4 results -> lsu_ready=0 after 4th push; entries drain in order once pipe_valid=0.
REQ-037 lsu push rd=0 data=32'hFFFF_FFFF -> entry popped, reg_write stays 0, occupancy decrements.
REQ-038 issue_valid with issue_rd=9 on the same cycle the FIFO head rd=9 is written -> busy[9]=1 afterward.
REQ-039 FIFO holding 3 entries, busy=32'h0000_0070, reset pulsed -> outputs zero, lsu_ready=1, no stale entry written after release.
